// File: rtl/display_scan_scheduler_if.sv
// Bus bundle for display_scan_scheduler.
//   master : drives load/data_in/en_mask/lz_en, observes status and scan outputs
//   slave  : the scheduler itself
// data_in is packed [NUM_DIG-1:0][3:0], which is bit-identical to a flat
// 4*NUM_DIG vector with digit k at [4k+3:4k].
interface display_scan_scheduler_if #(
  parameter int NUM_DIG = 8,
  parameter int IDX_W   = 3
);
  logic                    load;
  logic [NUM_DIG-1:0][3:0] data_in;
  logic [NUM_DIG-1:0]      en_mask;
  logic                    lz_en;
  logic                    busy;
  logic                    ack;
  logic                    frame_start;
  logic [IDX_W-1:0]        digit_idx;
  logic [3:0]              digit_bcd;
  logic [NUM_DIG-1:0]      anodo;

  modport master (
    output load, data_in, en_mask, lz_en,
    input  busy, ack, frame_start, digit_idx, digit_bcd, anodo
  );

  modport slave (
    input  load, data_in, en_mask, lz_en,
    output busy, ack, frame_start, digit_idx, digit_bcd, anodo
  );
endinterface

// File: rtl/display_scan_scheduler.sv
// Time-multiplexed 7-segment scan sequencer.
//   clk, rst : system clock, async active-high reset
//   bus      : slave side of display_scan_scheduler_if
//     load/data_in/en_mask/lz_en : staging write strobe and payload
//     busy/ack                   : staging pending / transferred-to-display pulse
//     frame_start                : pulse in first cycle of digit-0 slot
//     digit_idx/digit_bcd/anodo  : current slot, its nibble, active-low anodes
// Each slot is PRESC clocks; the first BLANK_CYC clocks keep all anodes off.
// Staging is copied to the display regs only on the frame boundary, so a
// frame never mixes old and new data.

// Per-digit anode decision: lit only when selected, past dead-time, enabled
// and not suppressed as a leading zero.
module dss_lane (
  input  logic sel_i,
  input  logic on_i,
  input  logic en_i,
  input  logic lz_i,
  output logic an_n_o
);
  assign an_n_o = ~(sel_i & on_i & en_i & ~lz_i);
endmodule

module display_scan_scheduler #(
  parameter int NUM_DIG   = 8,
  parameter int IDX_W     = 3,
  parameter int PRESC     = 50000,
  parameter int BLANK_CYC = 500
) (
  input logic                      clk,
  input logic                      rst,
  display_scan_scheduler_if.slave  bus
);
  localparam int CNT_W = $clog2(PRESC);

  typedef enum logic {ST_BLANK, ST_ON} state_t;
  localparam state_t ST_RST = (BLANK_CYC == 0) ? ST_ON : ST_BLANK;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_DIG-1:0][3:0] stg_data_q, stg_data_d;
  logic [NUM_DIG-1:0]      stg_en_q, stg_en_d;
  logic                    stg_lz_q, stg_lz_d;
  logic                    busy_q, busy_d;
  logic [NUM_DIG-1:0][3:0] disp_q, disp_d;
  logic [NUM_DIG-1:0]      en_q, en_d;
  logic [NUM_DIG-1:0]      lzm_q, lzm_d;
  logic                    ack_q, ack_d;
  logic                    fs_q, fs_d;
  logic [NUM_DIG-1:0]      anodo_q, anodo_d;
  logic [3:0]              bcd_q, bcd_d;

  logic [NUM_DIG-1:0]      lz_calc;
  logic [NUM_DIG-1:0]      lane_an;
  logic                    last_cyc, boundary, xfer;

  // Leading-zero mask from staging (the data about to be displayed):
  // digit k>0 is dark iff it and every higher nibble are zero.
  always_comb begin
    logic z;
    z       = 1'b1;
    lz_calc = '0;
    for (int k = NUM_DIG - 1; k >= 0; k--) begin
      z = z & (stg_data_q[k] == 4'd0);
      lz_calc[k] = (k != 0) & stg_lz_q & z;
    end
  end

  for (genvar k = 0; k < NUM_DIG; k++) begin : g_lane
    dss_lane u_lane (
      .sel_i  (idx_q == IDX_W'(k)),
      .on_i   (state_q == ST_ON),
      .en_i   (en_q[k]),
      .lz_i   (lzm_q[k]),
      .an_n_o (lane_an[k])
    );
  end

  always_comb begin
    cnt_d      = cnt_q + 1'b1;
    idx_d      = idx_q;
    stg_data_d = stg_data_q;
    stg_en_d   = stg_en_q;
    stg_lz_d   = stg_lz_q;
    busy_d     = busy_q;
    disp_d     = disp_q;
    en_d       = en_q;
    lzm_d      = lzm_q;
    ack_d      = 1'b0;

    last_cyc = (cnt_q == CNT_W'(PRESC - 1));
    boundary = last_cyc && (idx_q == IDX_W'(NUM_DIG - 1));
    xfer     = boundary && busy_q;

    if (last_cyc) begin
      cnt_d = '0;
      idx_d = boundary ? '0 : idx_q + 1'b1;
    end

    // State tracks the slot counter value it will be paired with.
    state_d = (int'(cnt_d) < BLANK_CYC) ? ST_BLANK : ST_ON;

    // Outputs lag the cnt/idx that select them by one clock, and anodes and
    // nibble are registered on the same edge so a lit digit never glitches.
    anodo_d = lane_an;
    bcd_d   = disp_q[idx_q];
    fs_d    = boundary;

    // Transfer uses the staging contents held before this edge; a load on
    // the boundary cycle lands in staging and stays pending.
    if (xfer) begin
      disp_d = stg_data_q;
      en_d   = stg_en_q;
      lzm_d  = lz_calc;
      ack_d  = 1'b1;
      busy_d = 1'b0;
    end

    if (bus.load) begin
      stg_data_d = bus.data_in;
      stg_en_d   = bus.en_mask;
      stg_lz_d   = bus.lz_en;
      busy_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RST;
      cnt_q      <= '0;
      idx_q      <= '0;
      stg_data_q <= '0;
      stg_en_q   <= '0;
      stg_lz_q   <= 1'b0;
      busy_q     <= 1'b0;
      disp_q     <= '0;
      en_q       <= '0;
      lzm_q      <= '0;
      ack_q      <= 1'b0;
      fs_q       <= 1'b0;
      anodo_q    <= '1;
      bcd_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      stg_data_q <= stg_data_d;
      stg_en_q   <= stg_en_d;
      stg_lz_q   <= stg_lz_d;
      busy_q     <= busy_d;
      disp_q     <= disp_d;
      en_q       <= en_d;
      lzm_q      <= lzm_d;
      ack_q      <= ack_d;
      fs_q       <= fs_d;
      anodo_q    <= anodo_d;
      bcd_q      <= bcd_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.ack         = ack_q;
  assign bus.frame_start = fs_q;
  assign bus.digit_idx   = idx_q;
  assign bus.digit_bcd   = bcd_q;
  assign bus.anodo       = anodo_q;
endmodule

// File: tb/tb_display_scan_scheduler.sv
module tb_display_scan_scheduler;
  localparam int ND = 4, IW = 2, PR = 8, BC = 2, FR = ND * PR;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  display_scan_scheduler_if #(.NUM_DIG(ND), .IDX_W(IW)) dif ();

  display_scan_scheduler #(.NUM_DIG(ND), .IDX_W(IW), .PRESC(PR), .BLANK_CYC(BC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0]     data;
    logic [3:0]      mask;
    logic            lz;
    logic [3:0][3:0] an;
    logic [3:0][3:0] bcd;
  } vec_t;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] bcd;
  } exp_t;

  exp_t sb[$];
  vec_t vt[6];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_load(logic [15:0] d, logic [3:0] m, logic lz);
    dif.load    = 1'b1;
    dif.data_in = d;
    dif.en_mask = m;
    dif.lz_en   = lz;
    tick();
    dif.load    = 1'b0;
  endtask

  task automatic push_vec(vec_t v);
    for (int k = 0; k < ND; k++) sb.push_back({v.an[k], v.bcd[k]});
  endtask

  task automatic wait_ack(string nm);
    int n = 0;
    while (dif.ack !== 1'b1 && n < 100) begin tick(); n++; end
    if (n >= 100) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic wait_fs(string nm);
    int n = 0;
    while (dif.frame_start !== 1'b1 && n < 100) begin tick(); n++; end
    if (n >= 100) chk({nm, "_timeout"}, 0, 1);
  endtask

  // Called at the negedge of the first cycle of a frame (t=0); returns at t=FR.
  // Outputs lag the slot counter by one clock: t=8k+1 is dead-time, t=8k+5 is lit.
  task automatic check_frame(string nm);
    exp_t e;
    chk({nm, "_fs0"}, dif.frame_start, 1);
    for (int t = 1; t <= FR; t++) begin
      tick();
      if (t < FR && t % PR == 1) chk({nm, "_blank"}, dif.anodo, 4'hF);
      if (t < FR && t % PR == 5) begin
        chk({nm, "_idx"}, dif.digit_idx, t / PR);
        if (sb.size() == 0) chk({nm, "_sb_empty"}, 0, 1);
        else begin
          e = sb.pop_front();
          chk({nm, "_anodo"}, dif.anodo, e.an);
          if (e.an != 4'hF) chk({nm, "_bcd"}, dif.digit_bcd, e.bcd);
        end
      end
    end
    chk({nm, "_fs_next"}, dif.frame_start, 1);
  endtask

  initial begin
    int n, bad;

    vt[0] = '{16'h4321, 4'hF, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {4'h4, 4'h3, 4'h2, 4'h1}};
    vt[1] = '{16'h0070, 4'hF, 1'b1, {4'b1111, 4'b1111, 4'b1101, 4'b1110}, {4'h0, 4'h0, 4'h7, 4'h0}};
    vt[2] = '{16'h0070, 4'hF, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {4'h0, 4'h0, 4'h7, 4'h0}};
    vt[3] = '{16'hB0C5, 4'hA, 1'b1, {4'b0111, 4'b1111, 4'b1101, 4'b1111}, {4'hB, 4'h0, 4'hC, 4'h5}};
    vt[4] = '{16'h0000, 4'hF, 1'b1, {4'b1111, 4'b1111, 4'b1111, 4'b1110}, {4'h0, 4'h0, 4'h0, 4'h0}};
    vt[5] = '{16'h0300, 4'h5, 1'b1, {4'b1111, 4'b1011, 4'b1111, 4'b1110}, {4'h0, 4'h3, 4'h0, 4'h0}};

    rst = 1'b1;
    dif.load = 1'b0; dif.data_in = '0; dif.en_mask = '0; dif.lz_en = 1'b0;
    #2;
    chk("rst_anodo", dif.anodo, 4'hF);
    chk("rst_bcd", dif.digit_bcd, 0);
    chk("rst_busy", dif.busy, 0);
    chk("rst_ack", dif.ack, 0);
    chk("rst_fs", dif.frame_start, 0);
    chk("rst_idx", dif.digit_idx, 0);
    tick();
    rst = 1'b0;

    // Idle frame: dark throughout, idx walks 0..3, frame_start period 32.
    wait_fs("idle_fs");
    bad = 0; n = 0;
    do begin
      tick(); n++;
      if (dif.anodo !== 4'hF) bad++;
      if (n % PR == 4 && n < FR) chk("idle_idx", dif.digit_idx, n / PR);
    end while (dif.frame_start !== 1'b1 && n < 100);
    chk("idle_dark", bad, 0);
    chk("idle_period", n, FR);

    // Table vectors.
    foreach (vt[i]) begin
      do_load(vt[i].data, vt[i].mask, vt[i].lz);
      chk("vec_busy", dif.busy, 1);
      push_vec(vt[i]);
      wait_ack("vec_ack");
      chk("vec_busy_clr", dif.busy, 0);
      check_frame("vec");
    end

    // Two loads in one frame: one ack, only the latest is shown.
    do_load(16'h1111, 4'hF, 1'b0);
    repeat (3) tick();
    do_load(16'h2222, 4'hF, 1'b0);
    push_vec('{16'h2222, 4'hF, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {4'h2, 4'h2, 4'h2, 4'h2}});
    wait_ack("dbl_ack");
    check_frame("dbl");
    n = 0;
    repeat (40) begin tick(); if (dif.ack === 1'b1) n++; end
    chk("dbl_single_ack", n, 0);

    // Load exactly on the boundary cycle while busy.
    wait_fs("bnd_fs");
    repeat (2) tick();
    do_load(16'h5555, 4'hF, 1'b0);          // now at t=3
    repeat (28) tick();                     // t=31: idx=3, cnt=7
    dif.load = 1'b1; dif.data_in = 16'h6666;
    tick();
    dif.load = 1'b0;
    chk("bnd_ack1", dif.ack, 1);
    chk("bnd_busy_kept", dif.busy, 1);
    push_vec('{16'h5555, 4'hF, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {4'h5, 4'h5, 4'h5, 4'h5}});
    check_frame("bnd_old");
    chk("bnd_ack2", dif.ack, 1);
    chk("bnd_busy_clr", dif.busy, 0);
    push_vec('{16'h6666, 4'hF, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {4'h6, 4'h6, 4'h6, 4'h6}});
    check_frame("bnd_new");

    // Reset mid-slot with data pending.
    do_load(16'h7777, 4'hF, 1'b0);
    repeat (2) tick();
    chk("mid_busy_pre", dif.busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_anodo", dif.anodo, 4'hF);
    chk("mid_bcd", dif.digit_bcd, 0);
    chk("mid_busy", dif.busy, 0);
    chk("mid_ack", dif.ack, 0);
    chk("mid_fs", dif.frame_start, 0);
    chk("mid_idx", dif.digit_idx, 0);
    tick();
    rst = 1'b0;
    n = 0; bad = 0;
    repeat (80) begin
      tick();
      if (dif.ack === 1'b1) n++;
      if (dif.anodo !== 4'hF) bad++;
    end
    chk("mid_no_ack", n, 0);
    chk("mid_dark", bad, 0);
    chk("mid_busy_post", dif.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
